// File: rtl/lsu_trigger_ctl.sv
// lsu_trigger_ctl: LSU debug trigger matcher. Each trigger compares the DC3 access
// address or size-qualified data against tdata2 (NAPOT, exact, >=, <). Even/odd
// triggers can be chained, and an occurrence counter makes a trigger fire only on
// every Nth qualified match. Fire pulses are registered and go to dec in DC4.
module lsu_trigger_ctl #(
    parameter int unsigned NUM_TRIG = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       rst_l,
    input  logic [NUM_TRIG-1:0]        trig_en,
    input  logic [NUM_TRIG-1:0]        trig_select,
    input  logic [NUM_TRIG-1:0]        trig_load,
    input  logic [NUM_TRIG-1:0]        trig_store,
    input  logic [2*NUM_TRIG-1:0]      trig_mode,
    input  logic [NUM_TRIG-1:0]        trig_chain,
    input  logic [CNT_W*NUM_TRIG-1:0]  trig_count,
    input  logic [DATA_W*NUM_TRIG-1:0] trig_tdata2,
    input  logic [NUM_TRIG-1:0]        trig_cfg_wr,
    input  logic [NUM_TRIG-1:0]        trig_hit_clr,
    input  logic                       lsu_valid_dc3,
    input  logic                       lsu_dma_dc3,
    input  logic                       lsu_load_dc3,
    input  logic                       lsu_store_dc3,
    input  logic [1:0]                 lsu_size_dc3,
    input  logic                       lsu_flush_dc3,
    input  logic [ADDR_W-1:0]          lsu_addr_dc3,
    input  logic [DATA_W-1:0]          lsu_load_data_dc3,
    input  logic [DATA_W-1:0]          lsu_store_data_dc3,
    output logic [NUM_TRIG-1:0]        lsu_trigger_match_dc4,
    output logic [NUM_TRIG-1:0]        lsu_trigger_hit_sticky
);

    logic [DATA_W-1:0]   data_raw;
    logic [DATA_W-1:0]   data_qual;
    logic [DATA_W-1:0]   addr_ext;
    logic [6:0]          size_bits;
    logic                access_ok;

    logic [DATA_W-1:0]   tdata     [NUM_TRIG];
    logic [DATA_W-1:0]   cmp_val   [NUM_TRIG];
    logic [DATA_W-1:0]   napot_ign [NUM_TRIG];
    logic [CNT_W-1:0]    count_val [NUM_TRIG];
    logic [NUM_TRIG-1:0] raw;
    logic [NUM_TRIG-1:0] qual;

    logic [CNT_W-1:0]    cnt_q [NUM_TRIG];
    logic [CNT_W-1:0]    cnt_d [NUM_TRIG];
    logic [NUM_TRIG-1:0] head_qual;
    logic [NUM_TRIG-1:0] reach;
    logic [NUM_TRIG-1:0] own_fire;
    logic [NUM_TRIG-1:0] fire;
    logic [NUM_TRIG-1:0] match_d, match_q;
    logic [NUM_TRIG-1:0] sticky_d, sticky_q;
    logic                unused_chain_odd;

    // Size-qualified access data, zero-extended address and access validity
    always_comb begin
        data_raw  = lsu_store_dc3 ? lsu_store_data_dc3 : lsu_load_data_dc3;
        data_qual = '0;
        case (lsu_size_dc3)
            2'd0:    size_bits = 7'd8;
            2'd1:    size_bits = 7'd16;
            2'd2:    size_bits = 7'd32;
            // dword; on a 32-bit datapath this degenerates to word
            default: size_bits = 7'(DATA_W);
        endcase
        for (int b = 0; b < DATA_W; b++) begin
            data_qual[b] = data_raw[b] & (7'(b) < size_bits);
        end
        addr_ext  = DATA_W'(lsu_addr_dc3);
        access_ok = lsu_valid_dc3 & ~lsu_dma_dc3 & ~lsu_flush_dc3;
    end

    // Raw compare and per-trigger access qualification
    always_comb begin
        raw  = '0;
        qual = '0;
        for (int i = 0; i < NUM_TRIG; i++) begin
            tdata[i]     = trig_tdata2[i*DATA_W +: DATA_W];
            count_val[i] = trig_count[i*CNT_W +: CNT_W];
            cmp_val[i]   = trig_select[i] ? data_qual : addr_ext;
            // Trailing ones and the lowest zero are don't-care, so 0x8000_0FFF
            // covers 0x8000_0000..0x8000_1FFF; all ones masks every bit.
            napot_ign[i] = tdata[i] ^ (tdata[i] + DATA_W'(1));
            case (trig_mode[2*i +: 2])
                2'd0:    raw[i] = ((cmp_val[i] ^ tdata[i]) & ~napot_ign[i]) == '0;
                2'd1:    raw[i] = cmp_val[i] == tdata[i];
                2'd2:    raw[i] = cmp_val[i] >= tdata[i];
                default: raw[i] = cmp_val[i] < tdata[i];
            endcase
            qual[i] = trig_en[i] & access_ok & raw[i] &
                      ((trig_store[i] & lsu_store_dc3) | (trig_load[i] & lsu_load_dc3));
        end
    end

    // Chaining, occurrence counting and fire generation
    always_comb begin
        head_qual        = '0;
        reach            = '0;
        own_fire         = '0;
        fire             = '0;
        unused_chain_odd = 1'b0;
        for (int p = 0; p < NUM_TRIG / 2; p++) begin
            unused_chain_odd = unused_chain_odd ^ trig_chain[2*p+1];
            if (trig_chain[2*p]) begin
                // Pair acts as one trigger; the odd counter holds
                head_qual[2*p] = qual[2*p] & qual[2*p+1];
            end else begin
                head_qual[2*p]   = qual[2*p];
                head_qual[2*p+1] = qual[2*p+1];
            end
        end
        for (int i = 0; i < NUM_TRIG; i++) begin
            cnt_d[i] = cnt_q[i];
            // >= rather than == so a shrunk trig_count still fires on the next match
            reach[i] = (count_val[i] <= CNT_W'(1)) ||
                       (({1'b0, cnt_q[i]} + (CNT_W+1)'(1)) >= {1'b0, count_val[i]});
            own_fire[i] = head_qual[i] & reach[i];
            if (trig_cfg_wr[i]) begin
                cnt_d[i] = '0;
            end else if (head_qual[i]) begin
                cnt_d[i] = reach[i] ? '0 : cnt_q[i] + CNT_W'(1);
            end
        end
        for (int p = 0; p < NUM_TRIG / 2; p++) begin
            fire[2*p]   = own_fire[2*p];
            fire[2*p+1] = trig_chain[2*p] ? own_fire[2*p] : own_fire[2*p+1];
        end
    end

    // Output next state: cfg_wr beats fire, fire beats hit_clr
    always_comb begin
        match_d  = fire & ~trig_cfg_wr;
        sticky_d = ~trig_cfg_wr & (fire | (sticky_q & ~trig_hit_clr));
    end

    // DC4 pulse, sticky status and occurrence counters
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            match_q  <= '0;
            sticky_q <= '0;
            for (int i = 0; i < NUM_TRIG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            match_q  <= match_d;
            sticky_q <= sticky_d;
            for (int i = 0; i < NUM_TRIG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign lsu_trigger_match_dc4  = match_q;
    assign lsu_trigger_hit_sticky = sticky_q;

endmodule

// File: tb/tb_lsu_trigger_ctl.sv
// Directed bench for lsu_trigger_ctl with the default 4-trigger, 64-bit configuration.
module tb_lsu_trigger_ctl;

    localparam int unsigned NT = 4;
    localparam int unsigned DW = 64;
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 8;

    logic            clk = 1'b0;
    logic            rst_l;
    logic [NT-1:0]   trig_en, trig_select, trig_load, trig_store, trig_chain;
    logic [2*NT-1:0] trig_mode;
    logic [CW*NT-1:0] trig_count;
    logic [DW*NT-1:0] trig_tdata2;
    logic [NT-1:0]   trig_cfg_wr, trig_hit_clr;
    logic            lsu_valid_dc3, lsu_dma_dc3, lsu_load_dc3, lsu_store_dc3, lsu_flush_dc3;
    logic [1:0]      lsu_size_dc3;
    logic [AW-1:0]   lsu_addr_dc3;
    logic [DW-1:0]   lsu_load_data_dc3, lsu_store_data_dc3;
    logic [NT-1:0]   match, sticky;

    int tests = 0;
    int fails = 0;

    lsu_trigger_ctl #(
        .NUM_TRIG (NT),
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .CNT_W    (CW)
    ) dut (
        .clk                    (clk),
        .rst_l                  (rst_l),
        .trig_en                (trig_en),
        .trig_select            (trig_select),
        .trig_load              (trig_load),
        .trig_store             (trig_store),
        .trig_mode              (trig_mode),
        .trig_chain             (trig_chain),
        .trig_count             (trig_count),
        .trig_tdata2            (trig_tdata2),
        .trig_cfg_wr            (trig_cfg_wr),
        .trig_hit_clr           (trig_hit_clr),
        .lsu_valid_dc3          (lsu_valid_dc3),
        .lsu_dma_dc3            (lsu_dma_dc3),
        .lsu_load_dc3           (lsu_load_dc3),
        .lsu_store_dc3          (lsu_store_dc3),
        .lsu_size_dc3           (lsu_size_dc3),
        .lsu_flush_dc3          (lsu_flush_dc3),
        .lsu_addr_dc3           (lsu_addr_dc3),
        .lsu_load_data_dc3      (lsu_load_data_dc3),
        .lsu_store_data_dc3     (lsu_store_data_dc3),
        .lsu_trigger_match_dc4  (match),
        .lsu_trigger_hit_sticky (sticky)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_cfg();
        trig_en     = '0;
        trig_select = '0;
        trig_load   = '0;
        trig_store  = '0;
        trig_chain  = '0;
        trig_mode   = '0;
        trig_count  = '0;
        trig_tdata2 = '0;
    endtask

    task automatic set_trig(input int i, input logic sel, input logic ld, input logic st,
                            input logic [1:0] mode, input logic [7:0] cnt,
                            input logic [63:0] td);
        trig_en[i]              = 1'b1;
        trig_select[i]          = sel;
        trig_load[i]            = ld;
        trig_store[i]           = st;
        trig_mode[2*i +: 2]     = mode;
        trig_count[i*CW +: CW]  = cnt;
        trig_tdata2[i*DW +: DW] = td;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_pulse(input logic [NT-1:0] m);
        trig_cfg_wr = m;
        idle();
        trig_cfg_wr = '0;
    endtask

    // One DC3 access; returns 1 ns after the edge that registers its result
    task automatic acc(input logic ld, input logic st, input logic [1:0] sz,
                       input logic [31:0] addr, input logic [63:0] ldata,
                       input logic [63:0] sdata);
        lsu_valid_dc3      = 1'b1;
        lsu_load_dc3       = ld;
        lsu_store_dc3      = st;
        lsu_size_dc3       = sz;
        lsu_addr_dc3       = addr;
        lsu_load_data_dc3  = ldata;
        lsu_store_data_dc3 = sdata;
        idle();
        lsu_valid_dc3 = 1'b0;
        lsu_load_dc3  = 1'b0;
        lsu_store_dc3 = 1'b0;
        lsu_flush_dc3 = 1'b0;
        lsu_dma_dc3   = 1'b0;
        trig_cfg_wr   = '0;
        trig_hit_clr  = '0;
    endtask

    task automatic ld_a(input logic [31:0] addr);
        acc(1'b1, 1'b0, 2'd2, addr, 64'h0, 64'h0);
    endtask

    task automatic st_a(input logic [31:0] addr);
        acc(1'b0, 1'b1, 2'd2, addr, 64'h0, 64'h0);
    endtask

    initial begin
        clear_cfg();
        trig_cfg_wr = '0; trig_hit_clr = '0;
        lsu_valid_dc3 = 0; lsu_dma_dc3 = 0; lsu_load_dc3 = 0; lsu_store_dc3 = 0;
        lsu_flush_dc3 = 0; lsu_size_dc3 = 0; lsu_addr_dc3 = '0;
        lsu_load_data_dc3 = '0; lsu_store_data_dc3 = '0;
        rst_l = 1'b1;
        #1 rst_l = 1'b0;
        #1;
        chk("reset_match", 32'(match), 32'h0);
        chk("reset_sticky", 32'(sticky), 32'h0);
        #10 rst_l = 1'b1;
        idle();

        // Address NAPOT, load-only trigger 0
        set_trig(0, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 64'h8000_0FFF);
        cfg_pulse(4'hF);
        ld_a(32'h8000_1234); chk("napot_in", 32'(match), 32'h1);
        chk("napot_sticky", 32'(sticky), 32'h1);
        idle();              chk("pulse_one_cycle", 32'(match), 32'h0);
        ld_a(32'h8000_2000); chk("napot_out_hi", 32'(match), 32'h0);
        ld_a(32'h8000_1FFF); chk("napot_top", 32'(match), 32'h1);
        ld_a(32'h7FFF_FFFF); chk("napot_out_lo", 32'(match), 32'h0);
        st_a(32'h8000_1234); chk("napot_store_unqual", 32'(match), 32'h0);
        trig_hit_clr = 4'h1;
        idle();
        trig_hit_clr = '0;
        chk("hit_clr", 32'(sticky), 32'h0);

        // Load/store data with size qualification, trigger 1
        clear_cfg();
        set_trig(1, 1'b1, 1'b1, 1'b0, 2'd1, 8'd0, 64'h78);
        cfg_pulse(4'hF);
        acc(1'b1, 1'b0, 2'd0, 32'h100, 64'hDEAD_BEEF_1234_5678, 64'h0);
        chk("data_byte", 32'(match), 32'h2);
        acc(1'b1, 1'b0, 2'd1, 32'h100, 64'hDEAD_BEEF_1234_5678, 64'h0);
        chk("data_half_nomatch", 32'(match), 32'h0);
        trig_tdata2[1*DW +: DW] = 64'hDEAD_BEEF_1234_5678;
        acc(1'b1, 1'b0, 2'd3, 32'h100, 64'hDEAD_BEEF_1234_5678, 64'h0);
        chk("data_dword", 32'(match), 32'h2);
        acc(1'b1, 1'b0, 2'd2, 32'h100, 64'hDEAD_BEEF_1234_5678, 64'h0);
        chk("data_word_trunc", 32'(match), 32'h0);
        set_trig(1, 1'b1, 1'b0, 1'b1, 2'd1, 8'd0, 64'h5678);
        acc(1'b0, 1'b1, 2'd1, 32'h100, 64'h0, 64'hFFFF_FFFF_FFFF_5678);
        chk("store_data_half", 32'(match), 32'h2);
        acc(1'b1, 1'b0, 2'd1, 32'h100, 64'h0, 64'hFFFF_FFFF_FFFF_5678);
        chk("store_trig_on_load", 32'(match), 32'h0);

        // NAPOT all ones matches everything
        clear_cfg();
        set_trig(3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_pulse(4'hF);
        ld_a(32'h1234_5678); chk("napot_all_ones", 32'(match), 32'h8);

        // Range chain: trig0 >= 0x1000, trig1 < 0x2000 (tail count ignored)
        clear_cfg();
        set_trig(0, 1'b0, 1'b0, 1'b1, 2'd2, 8'd0, 64'h1000);
        set_trig(1, 1'b0, 1'b0, 1'b1, 2'd3, 8'd3, 64'h2000);
        trig_chain = 4'h1;
        cfg_pulse(4'hF);
        st_a(32'h1800); chk("chain_in", 32'(match), 32'h3);
        st_a(32'h2000); chk("chain_lt_edge", 32'(match), 32'h0);
        st_a(32'h1000); chk("chain_ge_edge", 32'(match), 32'h3);
        st_a(32'h0FFF); chk("chain_below", 32'(match), 32'h0);
        chk("chain_sticky", 32'(sticky), 32'h3);

        // Occurrence count 3 on trigger 2
        clear_cfg();
        set_trig(2, 1'b0, 1'b1, 1'b0, 2'd1, 8'd3, 64'h40);
        cfg_pulse(4'hF);
        ld_a(32'h40); chk("cnt_1", 32'(match), 32'h0);
        ld_a(32'h40); chk("cnt_2", 32'(match), 32'h0);
        ld_a(32'h40); chk("cnt_3_fire", 32'(match), 32'h4);
        ld_a(32'h40); chk("cnt_4", 32'(match), 32'h0);
        ld_a(32'h44); chk("cnt_miss", 32'(match), 32'h0);
        ld_a(32'h40); chk("cnt_5", 32'(match), 32'h0);
        ld_a(32'h40); chk("cnt_6_fire", 32'(match), 32'h4);

        // Precedence, flush/DMA and count change on trigger 1 (count 2)
        clear_cfg();
        set_trig(1, 1'b0, 1'b0, 1'b1, 2'd1, 8'd2, 64'h80);
        cfg_pulse(4'hF);
        st_a(32'h80); chk("prec_first", 32'(match), 32'h0);
        trig_cfg_wr = 4'h2;
        st_a(32'h80); chk("cfgwr_no_pulse", 32'(match), 32'h0);
        chk("cfgwr_no_sticky", 32'(sticky), 32'h0);
        st_a(32'h80); chk("cfgwr_cnt_cleared", 32'(match), 32'h0);
        trig_hit_clr = 4'h2;
        st_a(32'h80); chk("fire_over_clr", 32'(match), 32'h2);
        chk("fire_over_clr_sticky", 32'(sticky), 32'h2);
        st_a(32'h80); chk("cnt_after_fire", 32'(match), 32'h0);
        lsu_flush_dc3 = 1'b1;
        st_a(32'h80); chk("flush_no_pulse", 32'(match), 32'h0);
        lsu_dma_dc3 = 1'b1;
        st_a(32'h80); chk("dma_no_pulse", 32'(match), 32'h0);
        st_a(32'h80); chk("cnt_held_fire", 32'(match), 32'h2);
        trig_count[1*CW +: CW] = 8'd5;
        st_a(32'h80);
        st_a(32'h80);
        st_a(32'h80); chk("cnt5_third", 32'(match), 32'h0);
        trig_count[1*CW +: CW] = 8'd2;
        st_a(32'h80); chk("count_shrunk_fire", 32'(match), 32'h2);

        // Reset mid-count: trig2 every 3rd load, trig3 every load
        clear_cfg();
        set_trig(2, 1'b0, 1'b1, 1'b0, 2'd1, 8'd3, 64'h40);
        set_trig(3, 1'b0, 1'b1, 1'b0, 2'd0, 8'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        cfg_pulse(4'hF);
        ld_a(32'h40);
        ld_a(32'h40);
        ld_a(32'h40); chk("rst_pre_fire", 32'(match), 32'hC);
        ld_a(32'h40);
        ld_a(32'h40); chk("rst_pre_cnt2", 32'(match), 32'h8);
        #2 rst_l = 1'b0;
        #1;
        chk("async_rst_match", 32'(match), 32'h0);
        chk("async_rst_sticky", 32'(sticky), 32'h0);
        #2 rst_l = 1'b1;
        ld_a(32'h40); chk("post_rst_1", 32'(match), 32'h8);
        ld_a(32'h40); chk("post_rst_2", 32'(match), 32'h8);
        ld_a(32'h40); chk("post_rst_3", 32'(match), 32'hC);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
